// File: rtl/boot_loader_pkg.sv
// boot_loader_pkg: shared state encoding and framing constants for the imem boot loader
package boot_loader_pkg;
  typedef enum logic [2:0] {S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;
  localparam int BYTES_PER_WORD = 4;
  localparam logic [7:0] CSUM_INIT = 8'h00;
endpackage

// File: rtl/byte_to_word_packer.sv
// byte_to_word_packer: assembles little-endian bytes into 32-bit words
module byte_to_word_packer
  import boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        accept,
  input  logic [7:0]  data,
  output logic        word_valid,
  output logic [31:0] word
);
  localparam int IW = $clog2(BYTES_PER_WORD);
  logic [IW-1:0] r_idx;
  logic [31:0]   r_word;
  // the incoming byte is merged combinationally so the completed word is available on its own accept edge
  always_comb begin
    word = r_word;
    word[{r_idx, 3'b000} +: 8] = data;
  end
  assign word_valid = accept && (r_idx == IW'(BYTES_PER_WORD - 1));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (clr) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (accept) begin
      r_idx  <= r_idx + IW'(1);
      r_word <= word;
    end
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a length-prefixed, XOR-checked byte stream into instruction memory
module imem_boot_loader
  import boot_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  input  logic                  load_req,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_rst_n,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  state_t                r_state, w_next;
  logic [15:0]           r_count;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [7:0]            r_csum;
  logic                  w_acc, w_restart, w_word_valid, w_last_word;
  logic [15:0]           w_len;
  logic [31:0]           w_word;
  assign in_ready    = r_state inside {S_LEN0, S_LEN1, S_DATA, S_CSUM};
  assign busy        = in_ready;
  assign w_acc       = in_valid && in_ready;
  assign w_restart   = load_req && (r_state inside {S_DONE, S_ERR});
  assign w_len       = {in_data, r_count[7:0]};
  assign w_last_word = w_word_valid && (17'(r_ptr) + 17'd1 == 17'(r_count));
  byte_to_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (w_restart),
    .accept     (w_acc && r_state == S_DATA),
    .data       (in_data),
    .word_valid (w_word_valid),
    .word       (w_word)
  );
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_LEN0:  w_next = w_acc ? S_LEN1 : S_LEN0;
      S_LEN1:  if (w_acc) w_next = (17'(w_len) > (17'd1 << ADDR_WIDTH)) ? S_ERR : (w_len == '0) ? S_CSUM : S_DATA;
      S_DATA:  if (w_last_word) w_next = S_CSUM;
      S_CSUM:  if (w_acc) w_next = (in_data == r_csum) ? S_DONE : S_ERR;
      default: if (load_req) w_next = S_LEN0;
    endcase
  end
  // status flags follow the state being entered so they update on the same edge
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state    <= S_LEN0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_rst_n <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      r_count    <= '0;
      r_ptr      <= '0;
      r_csum     <= CSUM_INIT;
    end else begin
      r_state    <= w_next;
      imem_we    <= w_word_valid;
      done       <= w_next == S_DONE;
      err        <= w_next == S_ERR;
      core_rst_n <= w_next == S_DONE;
      if (w_word_valid) begin
        imem_addr  <= r_ptr;
        imem_wdata <= w_word;
        r_ptr      <= r_ptr + ADDR_WIDTH'(1);
      end
      if (w_acc && r_state == S_LEN0) r_count[7:0] <= in_data;
      if (w_acc && r_state == S_LEN1) r_count[15:8] <= in_data;
      if (w_acc && r_state == S_DATA) r_csum <= r_csum ^ in_data;
      if (w_restart) begin
        r_count <= '0;
        r_ptr   <= '0;
        r_csum  <= CSUM_INIT;
      end
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: randomized self-checking bench with a byte-stream reference model
module tb_imem_boot_loader;
  logic        clk = 1'b0;
  logic        rst, in_valid, load_req, in_ready, imem_we, core_rst_n, busy, done, err;
  logic [7:0]  in_data, imem_addr;
  logic [31:0] imem_wdata;
  logic        v2, lr2, in_ready2, we2, core2, busy2, done2, err2;
  logic [7:0]  d2;
  logic [1:0]  addr2;
  logic [31:0] wdata2;
  logic [31:0] img [256];
  int          wa[$], wa2[$];
  logic [31:0] wd[$], wd2[$];
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  imem_boot_loader #(.ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .load_req(load_req), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst_n(core_rst_n), .busy(busy), .done(done), .err(err)
  );

  imem_boot_loader #(.ADDR_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_data(d2), .in_ready(in_ready2),
    .load_req(lr2), .imem_we(we2), .imem_addr(addr2), .imem_wdata(wdata2),
    .core_rst_n(core2), .busy(busy2), .done(done2), .err(err2)
  );

  always @(negedge clk) begin
    if (imem_we) begin wa.push_back(int'(imem_addr)); wd.push_back(imem_wdata); end
    if (we2) begin wa2.push_back(int'(addr2)); wd2.push_back(wdata2); end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  task automatic send(input logic [7:0] b, input int gap);
    in_valid = 1'b0;
    repeat ($urandom_range(0, gap)) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    for (int k = 0; k < 40; k++) begin
      if (in_ready) begin
        @(negedge clk);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; errors++;
    $display("FAIL send_timeout byte %h: in_ready=%b required 1", b, in_ready);
  endtask

  task automatic send2(input logic [7:0] b);
    v2 = 1'b1;
    d2 = b;
    for (int k = 0; k < 40; k++) begin
      if (in_ready2) begin
        @(negedge clk);
        v2 = 1'b0;
        return;
      end
      @(negedge clk);
    end
    v2 = 1'b0;
    checks++; errors++;
    $display("FAIL send2_timeout byte %h: in_ready=%b required 1", b, in_ready2);
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  // model: words go to addresses 0..n-1 in order, checksum is the XOR of all program bytes
  task automatic do_load(input string name, input int n, input bit bad, input int gap);
    logic [7:0] cs, b;
    int cnt;
    cs = 8'h00;
    wa.delete(); wd.delete();
    send(n[7:0], gap);
    send(n[15:8], gap);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 4; j++) begin
        b = img[i][8*j +: 8];
        cs ^= b;
        send(b, gap);
      end
    send(bad ? cs ^ 8'h01 : cs, gap);
    checks++;
    if (wa.size() != n) begin
      errors++;
      $display("FAIL %s write_count: got %0d required %0d", name, wa.size(), n);
    end
    cnt = (wa.size() < n) ? wa.size() : n;
    for (int i = 0; i < cnt; i++) begin
      checks++;
      if (wa[i] != i || wd[i] !== img[i]) begin
        errors++;
        $display("FAIL %s write%0d: got addr %0d data %h required addr %0d data %h", name, i, wa[i], wd[i], i, img[i]);
      end
    end
    checks++;
    if ({done, err, core_rst_n, in_ready, busy} !== {~bad, bad, ~bad, 2'b00}) begin
      errors++;
      $display("FAIL %s status done/err/core_rst_n/in_ready/busy: got %b required %b", name,
               {done, err, core_rst_n, in_ready, busy}, {~bad, bad, ~bad, 2'b00});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; load_req = 1'b0;
    v2 = 1'b0; d2 = '0; lr2 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({imem_we, imem_addr, imem_wdata, core_rst_n, done, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got we=%b addr=%h wdata=%h core_rst_n=%b done=%b err=%b required all 0",
               imem_we, imem_addr, imem_wdata, core_rst_n, done, err);
    end
    checks++;
    if ({in_ready, busy} !== 2'b11) begin
      errors++;
      $display("FAIL reset_ready_busy: got %b required 11", {in_ready, busy});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_normal();
    img[0] = 32'h00100513;
    img[1] = 32'h00000063;
    do_load("normal", 2, 1'b0, 0);
  endtask

  task automatic test_bad_csum();
    pulse_load();
    do_load("bad_csum", 2, 1'b1, 0);
  endtask

  task automatic test_overflow();
    logic [31:0] w [4];
    logic [7:0] cs;
    wa2.delete(); wd2.delete();
    send2(8'h05);
    send2(8'h00);
    checks++;
    if ({err2, done2, core2, in_ready2, busy2} !== 5'b10000) begin
      errors++;
      $display("FAIL overflow_status err/done/core/in_ready/busy: got %b required 10000",
               {err2, done2, core2, in_ready2, busy2});
    end
    checks++;
    if (wa2.size() != 0) begin
      errors++;
      $display("FAIL overflow_writes: got %0d required 0", wa2.size());
    end
    lr2 = 1'b1;
    @(negedge clk);
    lr2 = 1'b0;
    cs = 8'h00;
    send2(8'h04);
    send2(8'h00);
    for (int i = 0; i < 4; i++) begin
      w[i] = $urandom;
      for (int j = 0; j < 4; j++) begin
        cs ^= w[i][8*j +: 8];
        send2(w[i][8*j +: 8]);
      end
    end
    send2(cs);
    checks++;
    if ({done2, err2, core2} !== 3'b101) begin
      errors++;
      $display("FAIL capacity_status done/err/core: got %b required 101", {done2, err2, core2});
    end
    checks++;
    if (wa2.size() != 4) begin
      errors++;
      $display("FAIL capacity_write_count: got %0d required 4", wa2.size());
    end else
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wa2[i] != i || wd2[i] !== w[i]) begin
          errors++;
          $display("FAIL capacity_write%0d: got addr %0d data %h required addr %0d data %h", i, wa2[i], wd2[i], i, w[i]);
        end
      end
    pulse_load();
    wa.delete(); wd.delete();
    send(8'h01, 0);
    send(8'h01, 0);
    checks++;
    if ({err, done, busy} !== 3'b100 || wa.size() != 0) begin
      errors++;
      $display("FAIL overflow_hi_byte err/done/busy: got %b writes %0d required 100 writes 0", {err, done, busy}, wa.size());
    end
  endtask

  task automatic test_empty();
    pulse_load();
    do_load("empty", 0, 1'b0, 0);
  endtask

  task automatic test_gaps();
    int n;
    pulse_load();
    n = $urandom_range(1, 8);
    for (int i = 0; i < n; i++) img[i] = $urandom;
    do_load("gaps", n, 1'b0, 3);
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      int n;
      pulse_load();
      n = $urandom_range(0, 5);
      for (int i = 0; i < n; i++) img[i] = $urandom;
      do_load("random", n, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end
  endtask

  task automatic test_restart();
    pulse_load();
    do_load("pre_restart", 0, 1'b0, 0);
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({done, in_ready, busy} !== 3'b100) begin
      errors++;
      $display("FAIL done_holds done/in_ready/busy: got %b required 100", {done, in_ready, busy});
    end
    pulse_load();
    checks++;
    if ({done, err, core_rst_n, busy} !== 4'b0001) begin
      errors++;
      $display("FAIL restart_clear done/err/core_rst_n/busy: got %b required 0001", {done, err, core_rst_n, busy});
    end
    img[0] = 32'hDDCCBBAA;
    do_load("restart", 1, 1'b0, 0);
  endtask

  task automatic test_ignore_load_req();
    logic [31:0] w;
    logic [7:0] cs;
    pulse_load();
    wa.delete(); wd.delete();
    w = $urandom;
    cs = w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
    send(8'h01, 0);
    send(8'h00, 0);
    send(w[7:0], 0);
    send(w[15:8], 0);
    pulse_load();
    send(w[23:16], 0);
    send(w[31:24], 0);
    send(cs, 0);
    checks++;
    if (done !== 1'b1 || wa.size() != 1 || wd[0] !== w) begin
      errors++;
      $display("FAIL ignore_load_req: got done=%b writes=%0d data=%h required done=1 writes=1 data=%h",
               done, wa.size(), (wd.size() > 0) ? wd[0] : 32'hx, w);
    end
  endtask

  task automatic test_abort();
    pulse_load();
    wa.delete(); wd.delete();
    for (int i = 0; i < 3; i++) img[i] = $urandom | 32'h1;
    send(8'h03, 0);
    send(8'h00, 0);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 4; j++) send(img[i][8*j +: 8], 0);
    for (int j = 0; j < 3; j++) send(img[2][8*j +: 8], 0);
    checks++;
    if (imem_addr !== 8'd1 || imem_wdata !== img[1] || busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_abort: got addr %0d data %h busy %b required addr 1 data %h busy 1", imem_addr, imem_wdata, busy, img[1]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({imem_we, imem_addr, imem_wdata, core_rst_n, done, err} !== '0 || {in_ready, busy} !== 2'b11) begin
      errors++;
      $display("FAIL abort_async: got we=%b addr=%h wdata=%h core_rst_n=%b done=%b err=%b ready/busy=%b required zeros and 11",
               imem_we, imem_addr, imem_wdata, core_rst_n, done, err, {in_ready, busy});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    img[0] = $urandom;
    do_load("after_abort", 1, 1'b0, 1);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_bad_csum();
    test_overflow();
    test_empty();
    test_gaps();
    test_random();
    test_restart();
    test_ignore_load_req();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
